// File: rtl/adc_scan_ctrl_pkg.sv
// Shared constants, FSM encoding and channel/address helpers for the ADC128S022 scan sequencer.
package adc_scan_ctrl_pkg;

    localparam int ADC_FRAME_BITS     = 16;
    localparam int ADC_DATA_W         = 12;
    localparam int ADC_CH_W           = 3;
    localparam int ADC_NUM_CH         = 8;
    localparam int ADC_ADDR_FIRST_BIT = 2;
    localparam int ADC_DATA_FIRST_BIT = 4;
    localparam int HALF_W             = $clog2(2 * ADC_FRAME_BITS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SHIFT = 2'd2,
        ST_STOP  = 2'd3
    } state_e;

    // Lowest enabled channel strictly above 'last', wrapping; a lone bit maps back onto itself.
    function automatic logic [ADC_CH_W-1:0] next_ch(input logic [ADC_NUM_CH-1:0] mask,
                                                    input logic [ADC_CH_W-1:0]   last);
        logic [ADC_CH_W-1:0] c;
        logic                found;
        next_ch = last;
        found   = 1'b0;
        for (int i = 1; i <= ADC_NUM_CH; i++) begin
            c = last + ADC_CH_W'(i);
            if (!found && mask[c]) begin
                next_ch = c;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic addr_bit(input logic [ADC_CH_W-1:0] addr, input logic [3:0] k);
        addr_bit = 1'b0;
        for (int i = 0; i < ADC_CH_W; i++) begin
            if (k == 4'(ADC_ADDR_FIRST_BIT + i)) addr_bit = addr[ADC_CH_W-1-i];
        end
    endfunction

endpackage

// File: rtl/adc_scan_ctrl_sclk_gen.sv
// Half-period timer for the ADC serial clock: end-of-half strobe plus the SHIFT half-period index.
module adc_scan_ctrl_sclk_gen
    import adc_scan_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              shift_i,
    output logic              half_end_o,
    output logic [HALF_W-1:0] half_o,
    output logic [HALF_W-1:0] half_nxt_o
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HALF_W-1:0] half_q;

    assign half_end_o = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign half_o     = half_q;

    always_comb begin
        cnt_d      = '0;
        half_nxt_o = '0;
        if (run_i && !half_end_o) cnt_d = cnt_q + 1'b1;
        // Index is held at zero outside SHIFT so every frame begins on the bit-0 low phase.
        if (shift_i) half_nxt_o = half_end_o ? half_q + 1'b1 : half_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            half_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_nxt_o;
        end
    end

endmodule

// File: rtl/adc_scan_ctrl.sv
// ADC128S022 scan sequencer: frames CS_N/SCLK/SADDR, round-robins enabled channels and emits
// one tagged sample per frame (data of frame N belongs to the address sent in frame N-1).
module adc_scan_ctrl
    import adc_scan_ctrl_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [ADC_NUM_CH-1:0] ch_mask,
    output logic                  adc_cs_n,
    output logic                  adc_sclk,
    output logic                  adc_saddr,
    input  logic                  adc_sdat,
    output logic                  busy,
    output logic                  sample_valid,
    output logic [ADC_CH_W-1:0]   sample_ch,
    output logic [ADC_DATA_W-1:0] sample_data
);

    state_e                state_q, state_d;
    logic [ADC_CH_W-1:0]   addr_q, addr_d;
    logic [ADC_CH_W-1:0]   prev_addr_q, prev_addr_d;
    logic                  prev_valid_q, prev_valid_d;
    logic [ADC_DATA_W-1:0] data_q, data_d;
    logic                  cs_n_q, cs_n_d, sclk_q, sclk_d, saddr_q, saddr_d, busy_q, busy_d;
    logic                  valid_q, valid_d;
    logic [ADC_CH_W-1:0]   ch_q, ch_d;
    logic [ADC_DATA_W-1:0] sdata_q, sdata_d;

    logic                  half_end, go, rise;
    logic [HALF_W-1:0]     half_q, half_nxt;
    logic [3:0]            bit_k;

    adc_scan_ctrl_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk        (clk),
        .rst        (rst),
        .run_i      (state_q != ST_IDLE),
        .shift_i    (state_q == ST_SHIFT),
        .half_end_o (half_end),
        .half_o     (half_q),
        .half_nxt_o (half_nxt)
    );

    assign go    = enable && (|ch_mask);
    assign bit_k = half_q[HALF_W-1:1];
    // Last clk of a low half: SCLK rises on this edge, and DOUT has been stable since the fall.
    assign rise  = (state_q == ST_SHIFT) && half_end && !half_q[0];

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        prev_addr_d  = prev_addr_q;
        prev_valid_d = prev_valid_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        ch_d         = ch_q;
        sdata_d      = sdata_q;
        case (state_q)
            ST_IDLE: begin
                prev_valid_d = 1'b0;
                if (go) begin
                    state_d = ST_START;
                    addr_d  = next_ch(ch_mask, ADC_CH_W'(ADC_NUM_CH - 1));
                end
            end
            ST_START: begin
                if (half_end) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (rise && bit_k >= 4'(ADC_DATA_FIRST_BIT))
                    data_d = {data_q[ADC_DATA_W-2:0], adc_sdat};
                if (half_end && half_q == HALF_W'(2 * ADC_FRAME_BITS - 1)) begin
                    state_d      = ST_STOP;
                    valid_d      = prev_valid_q;
                    if (prev_valid_q) begin
                        ch_d    = prev_addr_q;
                        sdata_d = data_q;
                    end
                    prev_addr_d  = addr_q;
                    prev_valid_d = 1'b1;
                end
            end
            ST_STOP: begin
                if (half_end) begin
                    if (go) begin
                        state_d = ST_START;
                        addr_d  = next_ch(ch_mask, addr_q);
                    end else begin
                        state_d      = ST_IDLE;
                        prev_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pin drives are registered from the next state so they switch together with it.
        cs_n_d  = !(state_d == ST_START || state_d == ST_SHIFT);
        sclk_d  = !(state_d == ST_SHIFT && !half_nxt[0]);
        saddr_d = (state_d == ST_SHIFT) ? addr_bit(addr_q, half_nxt[HALF_W-1:1]) : 1'b0;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            prev_addr_q  <= '0;
            prev_valid_q <= 1'b0;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b1;
            saddr_q      <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            ch_q         <= '0;
            sdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            prev_addr_q  <= prev_addr_d;
            prev_valid_q <= prev_valid_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            saddr_q      <= saddr_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            ch_q         <= ch_d;
            sdata_q      <= sdata_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign adc_cs_n     = cs_n_q;
    assign adc_sclk     = sclk_q;
    assign adc_saddr    = saddr_q;
    assign busy         = busy_q;
    assign sample_valid = valid_q;
    assign sample_ch    = ch_q;
    assign sample_data  = sdata_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench: two sequencers (CLK_DIV 16 and 2), each wired to a behavioural ADC128S022 model.
module tb_adc_scan_ctrl;

    typedef struct {
        logic [7:0]  mask_pre;
        logic        en_pre;
        logic [7:0]  mask_mid;
        logic        en_mid;
        logic [2:0]  addr;
        logic        vld;
        logic [2:0]  ch;
        logic [11:0] data;
        logic        gap;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en1, en2;
    logic [7:0]  mask1, mask2;
    logic        cs1, sclk1, saddr1, busy1, vld1;
    logic        cs2, sclk2, saddr2, busy2, vld2;
    logic        sdat1 = 1'b0, sdat2 = 1'b0;
    logic [2:0]  ch1, ch2;
    logic [11:0] data1, data2;

    adc_scan_ctrl #(.CLK_DIV(16)) dut16 (
        .clk(clk), .rst(rst), .enable(en1), .ch_mask(mask1),
        .adc_cs_n(cs1), .adc_sclk(sclk1), .adc_saddr(saddr1), .adc_sdat(sdat1),
        .busy(busy1), .sample_valid(vld1), .sample_ch(ch1), .sample_data(data1)
    );

    adc_scan_ctrl #(.CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .enable(en2), .ch_mask(mask2),
        .adc_cs_n(cs2), .adc_sclk(sclk2), .adc_saddr(saddr2), .adc_sdat(sdat2),
        .busy(busy2), .sample_valid(vld2), .sample_ch(ch2), .sample_data(data2)
    );

    // ADC models: DOUT driven on SCLK fall, DIN sampled on SCLK rise, conversion of the
    // address received in the previous frame is shifted out in the current one.
    logic [11:0] mem1 [8];
    logic [11:0] mem2 [8];
    logic [2:0]  din1 = 3'd0, conv1 = 3'd0, din2 = 3'd0, conv2 = 3'd0;
    int          k1 = 0, k2 = 0;

    function automatic logic dout_bit(input logic [11:0] w, input int k);
        logic [15:0] f;
        f = {4'b0000, w};
        return (k >= 0 && k < 16) ? f[15-k] : 1'b0;
    endfunction

    always @(posedge sclk1 or posedge cs1) begin
        if (cs1) begin
            conv1 = din1;
            k1    = 0;
        end else begin
            if (k1 >= 2 && k1 <= 4) din1 = {din1[1:0], saddr1};
            k1 = k1 + 1;
        end
    end
    always @(negedge sclk1) if (!cs1) sdat1 <= dout_bit(mem1[conv1], k1);

    always @(posedge sclk2 or posedge cs2) begin
        if (cs2) begin
            conv2 = din2;
            k2    = 0;
        end else begin
            if (k2 >= 2 && k2 <= 4) din2 = {din2[1:0], saddr2};
            k2 = k2 + 1;
        end
    end
    always @(negedge sclk2) if (!cs2) sdat2 <= dout_bit(mem2[conv2], k2);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int lv [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic g_cs(input int s);    return (s != 0) ? cs2 : cs1;     endfunction
    function automatic logic g_vld(input int s);   return (s != 0) ? vld2 : vld1;   endfunction
    function automatic logic g_busy(input int s);  return (s != 0) ? busy2 : busy1; endfunction
    function automatic logic [2:0] g_ch(input int s);    return (s != 0) ? ch2 : ch1;     endfunction
    function automatic logic [2:0] g_din(input int s);   return (s != 0) ? din2 : din1;   endfunction
    function automatic logic [11:0] g_data(input int s); return (s != 0) ? data2 : data1; endfunction

    task automatic set_ctrl(input int s, input logic [7:0] m, input logic e);
        if (s != 0) begin
            mask2 = m;
            en2   = e;
        end else begin
            mask1 = m;
            en1   = e;
        end
    endtask

    function automatic vec_t mk(input logic [7:0] mp, input logic ep, input logic [7:0] mm,
                                input logic em, input logic [2:0] a, input logic v,
                                input logic [2:0] c, input logic [11:0] d, input logic g);
        vec_t r;
        r.mask_pre = mp; r.en_pre = ep; r.mask_mid = mm; r.en_mid = em;
        r.addr = a; r.vld = v; r.ch = c; r.data = d; r.gap = g;
        return r;
    endfunction

    // One frame: apply pre controls, wait for CS low, change controls mid-SHIFT, check at first STOP clk.
    task automatic run_row(input int s, input int idx, input vec_t v);
        int  div;
        bit  ok;
        div = (s != 0) ? 2 : 16;
        set_ctrl(s, v.mask_pre, v.en_pre);
        ok = 1'b0;
        for (int n = 0; n < 120 * div; n++) begin
            @(negedge clk);
            if (!g_cs(s)) begin ok = 1'b1; break; end
        end
        chk($sformatf("d%0d_r%0d_start", s, idx), 32'(ok), 1);
        if (!ok) return;
        repeat (6 * div) @(negedge clk);
        set_ctrl(s, v.mask_mid, v.en_mid);
        ok = 1'b0;
        for (int n = 0; n < 40 * div; n++) begin
            @(negedge clk);
            if (g_cs(s)) begin ok = 1'b1; break; end
        end
        chk($sformatf("d%0d_r%0d_end", s, idx), 32'(ok), 1);
        if (!ok) return;
        chk($sformatf("d%0d_r%0d_vld", s, idx), 32'(g_vld(s)), 32'(v.vld));
        chk($sformatf("d%0d_r%0d_busy", s, idx), 32'(g_busy(s)), 1);
        chk($sformatf("d%0d_r%0d_addr", s, idx), 32'(g_din(s)), 32'(v.addr));
        if (v.vld) begin
            chk($sformatf("d%0d_r%0d_ch", s, idx), 32'(g_ch(s)), 32'(v.ch));
            chk($sformatf("d%0d_r%0d_data", s, idx), 32'(g_data(s)), 32'(v.data));
            if (v.gap) chk($sformatf("d%0d_r%0d_gap", s, idx), cyc - lv[s], 34 * div);
            lv[s] = cyc;
            @(negedge clk);
            chk($sformatf("d%0d_r%0d_pulse", s, idx), 32'(g_vld(s)), 0);
        end
    endtask

    task automatic check_idle(input string nm);
        int lowcnt;
        repeat (40) @(negedge clk);
        chk({nm, "_busy"}, 32'(busy1), 0);
        chk({nm, "_cs"}, 32'(cs1), 1);
        lowcnt = 0;
        repeat (1200) begin
            @(negedge clk);
            if (!cs1) lowcnt++;
        end
        chk({nm, "_noframe"}, lowcnt, 0);
    endtask

    vec_t tab16 [14];
    vec_t tab2  [4];

    initial begin
        int  t1, t2, nf;
        bit  ok, prev;

        tab16[0]  = mk(8'h01, 1, 8'h01, 1, 3'd0, 0, 3'd0, 12'h000, 0);
        tab16[1]  = mk(8'h01, 1, 8'h01, 1, 3'd0, 1, 3'd0, 12'hA5C, 0);
        tab16[2]  = mk(8'h01, 1, 8'hA2, 1, 3'd0, 1, 3'd0, 12'hA5C, 1);
        tab16[3]  = mk(8'hA2, 1, 8'hA2, 1, 3'd1, 1, 3'd0, 12'hA5C, 1);
        tab16[4]  = mk(8'hA2, 1, 8'hA2, 1, 3'd5, 1, 3'd1, 12'h123, 1);
        tab16[5]  = mk(8'hA2, 1, 8'hA2, 1, 3'd7, 1, 3'd5, 12'hDEF, 1);
        tab16[6]  = mk(8'hA2, 1, 8'hA2, 1, 3'd1, 1, 3'd7, 12'hF0E, 1);
        tab16[7]  = mk(8'hA2, 1, 8'hA2, 0, 3'd5, 1, 3'd1, 12'h123, 1);
        tab16[8]  = mk(8'h0F, 1, 8'h0F, 1, 3'd0, 0, 3'd0, 12'h000, 0);
        tab16[9]  = mk(8'h0F, 1, 8'h0F, 1, 3'd1, 1, 3'd0, 12'hA5C, 0);
        tab16[10] = mk(8'h0F, 1, 8'h30, 1, 3'd2, 1, 3'd1, 12'h123, 1);
        tab16[11] = mk(8'h30, 1, 8'h30, 1, 3'd4, 1, 3'd2, 12'h456, 1);
        tab16[12] = mk(8'h30, 1, 8'h30, 1, 3'd5, 1, 3'd4, 12'hABC, 1);
        tab16[13] = mk(8'h30, 1, 8'h00, 1, 3'd4, 1, 3'd5, 12'hDEF, 1);
        tab2[0]   = mk(8'h07, 1, 8'h07, 1, 3'd0, 0, 3'd0, 12'h000, 0);
        tab2[1]   = mk(8'h07, 1, 8'h07, 1, 3'd1, 1, 3'd0, 12'h000, 0);
        tab2[2]   = mk(8'h07, 1, 8'h07, 1, 3'd2, 1, 3'd1, 12'hFFF, 1);
        tab2[3]   = mk(8'h07, 1, 8'h07, 0, 3'd0, 1, 3'd2, 12'h801, 1);

        mem1[0] = 12'hA5C; mem1[1] = 12'h123; mem1[2] = 12'h456; mem1[3] = 12'h789;
        mem1[4] = 12'hABC; mem1[5] = 12'hDEF; mem1[6] = 12'h135; mem1[7] = 12'hF0E;
        mem2[0] = 12'h000; mem2[1] = 12'hFFF; mem2[2] = 12'h801; mem2[3] = 12'h5A5;
        mem2[4] = 12'h5A5; mem2[5] = 12'h5A5; mem2[6] = 12'h5A5; mem2[7] = 12'h5A5;
        lv[0] = 0;
        lv[1] = 0;

        rst = 1'b1; en1 = 1'b0; en2 = 1'b0; mask1 = 8'h00; mask2 = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs1), 1);
        chk("rst_sclk", 32'(sclk1), 1);
        chk("rst_saddr", 32'(saddr1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_valid", 32'(vld1), 0);
        chk("rst_ch", 32'(ch1), 0);
        chk("rst_data", 32'(data1), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_rst_busy", 32'(busy1), 0);

        for (int i = 0; i < 8; i++) run_row(0, i, tab16[i]);
        check_idle("enable_off");
        for (int i = 8; i < 14; i++) run_row(0, i, tab16[i]);
        check_idle("mask_zero");

        for (int i = 0; i < 4; i++) run_row(1, i, tab2[i]);

        // SCLK period at CLK_DIV=2
        set_ctrl(1, 8'h07, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (!cs2) begin ok = 1'b1; break; end
        end
        chk("div2_start", 32'(ok), 1);
        t1 = 0; t2 = 0; nf = 0; prev = sclk2;
        for (int n = 0; n < 40 && nf < 2; n++) begin
            @(negedge clk);
            if (prev && !sclk2) begin
                if (nf == 0) t1 = cyc; else t2 = cyc;
                nf++;
            end
            prev = sclk2;
        end
        chk("div2_sclk_period", t2 - t1, 4);
        set_ctrl(1, 8'h07, 1'b0);
        repeat (200) @(negedge clk);

        // Asynchronous reset in the middle of a frame, between clock edges
        set_ctrl(0, 8'h01, 1'b1);
        ok = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!cs1 && !sclk1) begin ok = 1'b1; break; end
        end
        chk("arst_reach_shift", 32'(ok), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_cs_n", 32'(cs1), 1);
        chk("arst_sclk", 32'(sclk1), 1);
        chk("arst_saddr", 32'(saddr1), 0);
        chk("arst_busy", 32'(busy1), 0);
        chk("arst_valid", 32'(vld1), 0);
        chk("arst_ch", 32'(ch1), 0);
        chk("arst_data", 32'(data1), 0);
        en1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("arst_release_idle", 32'(busy1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
